// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA scan-out path.
package vga_pkg;

   typedef logic [2:0] pixel_t;

   localparam int unsigned DEF_WIGHT   = 640;
   localparam int unsigned DEF_HEIGHT  = 480;
   localparam int unsigned DEF_H_FRONT = 16;
   localparam int unsigned DEF_H_SYNC  = 96;
   localparam int unsigned DEF_H_BACK  = 48;
   localparam int unsigned DEF_V_FRONT = 10;
   localparam int unsigned DEF_V_SYNC  = 2;
   localparam int unsigned DEF_V_BACK  = 33;
   localparam int unsigned DEF_HT      = DEF_WIGHT + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int unsigned DEF_VT      = DEF_HEIGHT + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int unsigned ADDR_W      = 19;

endpackage

// File: rtl/ram2vga_if.sv
// Frame-RAM read port plus VGA pin bundle; master is the scan-out block.
// test_mode exists only when RAM2VGA_TESTPATTERN_EN is defined.
interface ram2vga_if;
   import vga_pkg::*;

   logic              read_ram;
   logic [ADDR_W-1:0] address_ram;
   pixel_t            ram_q;
   pixel_t            rgb;
   logic              hsync;
   logic              vsync;
   logic              de;
   logic              frame_start;
`ifdef RAM2VGA_TESTPATTERN_EN
   logic              test_mode;
`endif

   modport master (
      output read_ram, address_ram, rgb, hsync, vsync, de, frame_start,
`ifdef RAM2VGA_TESTPATTERN_EN
      input  test_mode,
`endif
      input  ram_q
   );

   modport slave (
      input  read_ram, address_ram, rgb, hsync, vsync, de, frame_start,
`ifdef RAM2VGA_TESTPATTERN_EN
      output test_mode,
`endif
      output ram_q
   );

endinterface

// File: rtl/vga_timing.sv
// Raster counters with registered visible/sync/frame-start flags aligned to the counter stage.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned Wight   = DEF_WIGHT,
   parameter int unsigned Height  = DEF_HEIGHT,
   parameter int unsigned H_FRONT = DEF_H_FRONT,
   parameter int unsigned H_SYNC  = DEF_H_SYNC,
   parameter int unsigned H_BACK  = DEF_H_BACK,
   parameter int unsigned V_FRONT = DEF_V_FRONT,
   parameter int unsigned V_SYNC  = DEF_V_SYNC,
   parameter int unsigned V_BACK  = DEF_V_BACK
) (
   input  logic clk,
   input  logic rst,
   output logic vis_o,
   output logic hsync_o,
   output logic vsync_o,
   output logic frame_start_o
);
   localparam int unsigned HT  = Wight + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VT  = Height + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned H_W = $clog2(HT);
   localparam int unsigned V_W = $clog2(VT);

   logic           run_q;
   logic [H_W-1:0] h_q, h_d;
   logic [V_W-1:0] v_q, v_d;
   logic           vis_q, vis_d;
   logic           hs_q, hs_d;
   logic           vs_q, vs_d;
   logic           fs_q, fs_d;

   // run_q spends one cycle after reset presenting (0,0) with frame_start before counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q <= 1'b0;
         h_q   <= '0;
         v_q   <= '0;
         vis_q <= 1'b0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         fs_q  <= 1'b0;
      end else begin
         run_q <= 1'b1;
         h_q   <= h_d;
         v_q   <= v_d;
         vis_q <= vis_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         fs_q  <= fs_d;
      end
   end

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (run_q) begin
         if (h_q == H_W'(HT - 1)) begin
            h_d = '0;
            v_d = (v_q == V_W'(VT - 1)) ? '0 : v_q + V_W'(1);
         end else begin
            h_d = h_q + H_W'(1);
         end
      end
      vis_d = (h_d < H_W'(Wight)) && (v_d < V_W'(Height));
      hs_d  = !((h_d >= H_W'(Wight + H_FRONT)) && (h_d < H_W'(Wight + H_FRONT + H_SYNC)));
      vs_d  = !((v_d >= V_W'(Height + V_FRONT)) && (v_d < V_W'(Height + V_FRONT + V_SYNC)));
      fs_d  = (h_d == '0) && (v_d == '0);
   end

   assign vis_o         = vis_q;
   assign hsync_o       = hs_q;
   assign vsync_o       = vs_q;
   assign frame_start_o = fs_q;

endmodule

// File: rtl/ram2vga.sv
// VGA scan-out reader: sequential frame-RAM reads per visible pixel, sync/de realigned with data.
// Optional 8-bar colour test pattern enabled by defining RAM2VGA_TESTPATTERN_EN.
module ram2vga
   import vga_pkg::*;
#(
   parameter int unsigned Wight       = DEF_WIGHT,
   parameter int unsigned Height      = DEF_HEIGHT,
   parameter int unsigned H_FRONT     = DEF_H_FRONT,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BACK      = DEF_H_BACK,
   parameter int unsigned V_FRONT     = DEF_V_FRONT,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BACK      = DEF_V_BACK,
   parameter int unsigned RAM_LATENCY = 1
) (
   input logic       clk,
   input logic       rst,
   ram2vga_if.master bus
);
   localparam int unsigned DL = RAM_LATENCY;

   logic vis, hs, vs, fs;

   vga_timing #(
      .Wight   (Wight),
      .Height  (Height),
      .H_FRONT (H_FRONT),
      .H_SYNC  (H_SYNC),
      .H_BACK  (H_BACK),
      .V_FRONT (V_FRONT),
      .V_SYNC  (V_SYNC),
      .V_BACK  (V_BACK)
   ) u_timing (
      .clk           (clk),
      .rst           (rst),
      .vis_o         (vis),
      .hsync_o       (hs),
      .vsync_o       (vs),
      .frame_start_o (fs)
   );

   logic [ADDR_W-1:0] addr_q, addr_d, addr_cur;
   logic [ADDR_W-1:0] address_ram_q, address_ram_d;
   logic              read_ram_q, read_ram_d;
   logic [DL:0]       de_pipe_q, de_pipe_d;
   logic [DL:0]       hs_pipe_q, hs_pipe_d;
   logic [DL:0]       vs_pipe_q, vs_pipe_d;
   pixel_t            rgb_q, rgb_d;
   logic              de_q, de_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;

`ifdef RAM2VGA_TESTPATTERN_EN
   localparam int unsigned BAR_W = Wight / 8;
   localparam int unsigned PX_W  = $clog2(BAR_W);

   logic             tm;
   logic [PX_W-1:0]  px_q, px_d;
   pixel_t           bar_q, bar_d;
   logic [DL:0]      tm_pipe_q, tm_pipe_d;
   logic [DL:0][2:0] bar_pipe_q, bar_pipe_d;

   assign tm = bus.test_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         px_q       <= '0;
         bar_q      <= '0;
         tm_pipe_q  <= '0;
         bar_pipe_q <= '0;
      end else begin
         px_q       <= px_d;
         bar_q      <= bar_d;
         tm_pipe_q  <= tm_pipe_d;
         bar_pipe_q <= bar_pipe_d;
      end
   end

   // bar_q tracks h/BAR_W during visible cycles without a divider
   always_comb begin
      px_d  = '0;
      bar_d = '0;
      if (vis) begin
         if (px_q == PX_W'(BAR_W - 1)) begin
            px_d  = '0;
            bar_d = bar_q + 3'(1);
         end else begin
            px_d  = px_q + PX_W'(1);
            bar_d = bar_q;
         end
      end
      tm_pipe_d  = {tm_pipe_q[DL-1:0], tm};
      bar_pipe_d = {bar_pipe_q[DL-1:0], bar_q};
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q        <= '0;
         address_ram_q <= '0;
         read_ram_q    <= 1'b0;
         de_pipe_q     <= '0;
         hs_pipe_q     <= '1;
         vs_pipe_q     <= '1;
         rgb_q         <= '0;
         de_q          <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
      end else begin
         addr_q        <= addr_d;
         address_ram_q <= address_ram_d;
         read_ram_q    <= read_ram_d;
         de_pipe_q     <= de_pipe_d;
         hs_pipe_q     <= hs_pipe_d;
         vs_pipe_q     <= vs_pipe_d;
         rgb_q         <= rgb_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
      end
   end

   // Pipe index DL is the cycle in which ram_q answers the stage-1 read
   always_comb begin
      addr_cur      = fs ? '0 : addr_q;
      addr_d        = vis ? addr_cur + ADDR_W'(1) : addr_cur;
      address_ram_d = addr_cur;
      read_ram_d    = vis;
      de_pipe_d     = {de_pipe_q[DL-1:0], vis};
      hs_pipe_d     = {hs_pipe_q[DL-1:0], hs};
      vs_pipe_d     = {vs_pipe_q[DL-1:0], vs};
      de_d          = de_pipe_q[DL];
      hsync_d       = hs_pipe_q[DL];
      vsync_d       = vs_pipe_q[DL];
      rgb_d         = de_pipe_q[DL] ? bus.ram_q : '0;
`ifdef RAM2VGA_TESTPATTERN_EN
      read_ram_d    = vis & ~tm;
      if (de_pipe_q[DL] && tm_pipe_q[DL]) begin
         rgb_d = bar_pipe_q[DL];
      end
`endif
   end

   assign bus.read_ram    = read_ram_q;
   assign bus.address_ram = address_ram_q;
   assign bus.rgb         = rgb_q;
   assign bus.de          = de_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.frame_start = fs;

endmodule

// File: tb/tb_ram2vga.sv
// Bench for ram2vga: a default 640x480 instance (latency 1) and a shrunken raster (latency 3)
// checked every cycle against an arithmetic raster model; RAM answers address[2:0].
module tb_ram2vga;
   import vga_pkg::*;

   typedef struct packed {int w; int h; int hf; int hs; int hb; int vf; int vs; int vb; int l;} geom_t;
   typedef struct packed {logic rd; logic [18:0] addr; logic [2:0] rgb; logic hs; logic vs; logic de; logic fs;} obs_t;

   localparam geom_t G_DEF = '{w:640, h:480, hf:16, hs:96, hb:48, vf:10, vs:2, vb:33, l:1};
   localparam geom_t G_SML = '{w:16, h:6, hf:2, hs:3, hb:3, vf:1, vs:2, vb:1, l:3};
   localparam int SML_FRAME = 240;

   logic clk = 1'b0;
   logic rst;
   bit   tm;
   int   t_cyc;
   int   last_fs;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ram2vga_if bus_d ();
   ram2vga_if bus_s ();

   ram2vga #(.RAM_LATENCY(1)) u_def (.clk(clk), .rst(rst), .bus(bus_d));

   ram2vga #(
      .Wight(16), .Height(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .RAM_LATENCY(3)
   ) u_sml (.clk(clk), .rst(rst), .bus(bus_s));

   // RAM models: return address[2:0] after the latency, junk when not reading
   logic [2:0] mem_d [3];
   logic [2:0] mem_s [3];
   always @(posedge clk) begin
      mem_d[0] <= bus_d.read_ram ? bus_d.address_ram[2:0] : 3'($urandom);
      mem_d[1] <= mem_d[0];
      mem_d[2] <= mem_d[1];
      mem_s[0] <= bus_s.read_ram ? bus_s.address_ram[2:0] : 3'($urandom);
      mem_s[1] <= mem_s[0];
      mem_s[2] <= mem_s[1];
   end
   assign bus_d.ram_q = mem_d[0];
   assign bus_s.ram_q = mem_s[2];

`ifdef RAM2VGA_TESTPATTERN_EN
   assign bus_d.test_mode = tm;
   assign bus_s.test_mode = tm;
`endif

   // Expected outputs t cycles after the first (0,0) counter cycle
   function automatic obs_t model(geom_t g, int t, bit tmode);
      int   ht, vt, s, h, v;
      obs_t e;
      ht = g.w + g.hf + g.hs + g.hb;
      vt = g.h + g.vf + g.vs + g.vb;
      e = '{rd:1'b0, addr:'0, rgb:'0, hs:1'b1, vs:1'b1, de:1'b0, fs:1'b0};
      e.fs = (t % (ht * vt)) == 0;
      s = t - 1;
      if (s >= 0) begin
         h = s % ht;
         v = (s / ht) % vt;
         if (h < g.w && v < g.h) begin
            e.rd   = !tmode;
            e.addr = 19'(v * g.w + h);
         end
      end
      s = t - g.l - 2;
      if (s >= 0) begin
         h = s % ht;
         v = (s / ht) % vt;
         e.hs = !(h >= g.w + g.hf && h < g.w + g.hf + g.hs);
         e.vs = !(v >= g.h + g.vf && v < g.h + g.vf + g.vs);
         if (h < g.w && v < g.h) begin
            e.de  = 1'b1;
            e.rgb = tmode ? 3'(h / (g.w / 8)) : 3'((v * g.w + h) % 8);
         end
      end
      return e;
   endfunction

   function automatic obs_t obs_def();
      obs_t a;
      a.rd = bus_d.read_ram; a.addr = bus_d.address_ram; a.rgb = bus_d.rgb;
      a.hs = bus_d.hsync; a.vs = bus_d.vsync; a.de = bus_d.de; a.fs = bus_d.frame_start;
      return a;
   endfunction

   function automatic obs_t obs_sml();
      obs_t a;
      a.rd = bus_s.read_ram; a.addr = bus_s.address_ram; a.rgb = bus_s.rgb;
      a.hs = bus_s.hsync; a.vs = bus_s.vsync; a.de = bus_s.de; a.fs = bus_s.frame_start;
      return a;
   endfunction

   task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t_cyc, obs, exp);
      end
   endtask

   task automatic check_obs(string name, obs_t a, obs_t e, bit chk_addr);
      cmp({name, ".read_ram"}, 32'(a.rd), 32'(e.rd));
      if (chk_addr || e.rd) cmp({name, ".address_ram"}, 32'(a.addr), 32'(e.addr));
      cmp({name, ".rgb"}, 32'(a.rgb), 32'(e.rgb));
      cmp({name, ".hsync"}, 32'(a.hs), 32'(e.hs));
      cmp({name, ".vsync"}, 32'(a.vs), 32'(e.vs));
      cmp({name, ".de"}, 32'(a.de), 32'(e.de));
      cmp({name, ".frame_start"}, 32'(a.fs), 32'(e.fs));
   endtask

   task automatic check_reset();
      obs_t r = '{rd:1'b0, addr:'0, rgb:'0, hs:1'b1, vs:1'b1, de:1'b0, fs:1'b0};
      check_obs("rst.def", obs_def(), r, 1'b1);
      check_obs("rst.sml", obs_sml(), r, 1'b1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_obs("def", obs_def(), model(G_DEF, t_cyc, tm), 1'b0);
      check_obs("sml", obs_sml(), model(G_SML, t_cyc, tm), 1'b0);
      if (bus_s.frame_start === 1'b1) begin
         if (last_fs >= 0) cmp("sml.fs_period", 32'(t_cyc - last_fs), 32'(SML_FRAME));
         last_fs = t_cyc;
      end
      t_cyc++;
   endtask

   initial begin
      rst     = 1'b1;
      tm      = 1'b0;
      t_cyc   = 0;
      last_fs = -1;

      // Reset held five clocks, outputs inactive throughout
      repeat (5) begin
         @(negedge clk);
         check_reset();
      end
      rst = 1'b0;

      // Default raster: lines 0..2 incl. hsync window; small raster: 8+ full frames
      repeat (2000) step();

      // Mid-frame reset at small-raster line 3, pixel 5, asserted between edges
      while ((t_cyc % SML_FRAME) != 3 * 24 + 5) step();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset();
      repeat (3) begin
         @(negedge clk);
         check_reset();
      end
      rst     = 1'b0;
      t_cyc   = 0;
      last_fs = -1;
      repeat (600) step();

`ifdef RAM2VGA_TESTPATTERN_EN
      @(negedge clk);
      rst = 1'b1;
      tm  = 1'b1;
      @(negedge clk);
      check_reset();
      rst     = 1'b0;
      t_cyc   = 0;
      last_fs = -1;
      repeat (900) step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
